product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 12, meaning accumulator/sum width in bits.
REQ-002 SHALL have parameter CNT_W, default 4, meaning width of the beat-count input.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, begins a new accumulation run; sampled only in IDLE.
REQ-006 SHALL have port count, input, CNT_W, number of products to sum in the run; sampled with start.
REQ-007 SHALL have port R, input, 8, unsigned product from the upstream 4x4 multiplier stage.
REQ-008 SHALL have port in_valid, input, 1, R holds a valid product this cycle.
REQ-009 SHALL have port in_ready, output, 1, block accepts R this cycle.
REQ-010 SHALL have port sum, output, ACC_W, registered accumulated result.
REQ-011 SHALL have port out_valid, output, 1, sum holds a completed result.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts sum this cycle.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, ACC, DONE.
REQ-015 SHALL, in IDLE with start=1 and count!=0, clear the accumulator, load remaining=count and enter ACC next cycle.
REQ-016 SHALL, in IDLE with start=1 and count=0, clear the accumulator and enter DONE next cycle (sum=0).
REQ-017 SHALL drive in_ready=1 only in ACC; a beat is accepted when in_valid and in_ready are both 1.
REQ-018 SHALL, per accepted beat, add R zero-extended to ACC_W into the accumulator and decrement remaining.
REQ-019 SHALL, on the beat accepted with remaining=1, enter DONE; out_valid rises the cycle after that beat.
REQ-020 SHALL hold sum and out_valid stable in DONE until out_ready=1, then return to IDLE next cycle with out_valid=0.
REQ-021 SHALL ignore start in ACC and DONE; SHALL ignore R and in_valid outside ACC.
REQ-022 SHALL wait indefinitely in ACC while in_valid=0 with no change to accumulator or remaining.
REQ-023 SHALL wrap the accumulator modulo 2^ACC_W; with defaults, maximum legal total 15*225=3375 does not wrap.
REQ-024 SHALL keep sum equal to the accumulator register at all times (no combinational path from R to sum).

Reset
REQ-025 SHALL, on rst=1 at any time including mid-run, immediately force IDLE, sum=0, remaining=0, out_valid=0, in_ready=0, busy=0.
REQ-026 SHALL, after rst deasserts, require a fresh start; any partial sum is discarded.

Structure
REQ-027 SHALL place FSM state encodings (IDLE=2'd0, ACC=2'd1, DONE=2'd2) and default ACC_W/CNT_W constants in a shared package.
REQ-028 SHALL use one sub-module, acc_adder, an ACC_W-bit combinational adder forming the next accumulator value; FSM, counter and registers stay in product_accumulator.

Verification
REQ-029 SHALL cover basic run: start with count=3, products 6, 15, 225 on consecutive cycles with in_valid=1 -> out_valid one cycle after third beat, sum=246.
REQ-030 SHALL cover stalls: count=2, products 9 and 4 with in_valid gaps of 3 cycles -> sum=13, in_ready high throughout ACC, no extra beats counted.
REQ-031 SHALL cover zero count: start with count=0 -> out_valid next cycle, sum=0, in_ready never high.
REQ-032 SHALL cover backpressure: run completes with out_ready=0 for 5 cycles -> sum and out_valid stable; out_ready=1 -> IDLE next cycle; start pulses during DONE ignored.
REQ-033 SHALL cover reset mid-run: count=15, rst asserted after 7 beats -> all outputs 0 asynchronously; subsequent start with count=1 and product 200 -> sum=200.
REQ-034 SHALL cover maximum: count=15, all products 225 -> sum=3375, no wrap.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// Shared constants and FSM encoding for the product accumulator.
//   ACC_W_DEF / CNT_W_DEF : default accumulator and beat-count widths
//   PROD_W                : width of one upstream 4x4 product
//   state_e               : IDLE / ACC / DONE encodings
package product_accumulator_pkg;

  localparam int unsigned ACC_W_DEF = 12;
  localparam int unsigned CNT_W_DEF = 4;
  localparam int unsigned PROD_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/acc_adder.sv
// Combinational ACC_W-bit adder forming the next accumulator value.
//   a_i   : current accumulator
//   b_i   : zero-extended product
//   sum_o : a_i + b_i, wrapping modulo 2^ACC_W
module acc_adder #(
  parameter int unsigned ACC_W = 12
) (
  input  logic [ACC_W-1:0] a_i,
  input  logic [ACC_W-1:0] b_i,
  output logic [ACC_W-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/product_accumulator.sv
// Sums a programmed number of 8-bit products and hands the total downstream
// with a valid/ready handshake.
//   clk, rst            : clock, asynchronous active-high reset
//   start, count        : launch a run of 'count' beats (sampled in IDLE)
//   R, in_valid/in_ready: product input handshake (ready only in ACC)
//   sum, out_valid/ready: registered result handshake (held in DONE)
//   busy                : high whenever the FSM is not IDLE
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  input  logic [PROD_W-1:0] R,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               in_ready_q, out_valid_q, busy_q;
  logic [ACC_W-1:0]   add_c;

  // Next accumulator value for an accepted beat
  acc_adder #(.ACC_W(ACC_W)) u_acc_adder (
    .a_i   (acc_q),
    .b_i   (ACC_W'(R)),
    .sum_o (add_c)
  );

  // State and datapath registers; status flags are registered from the
  // next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      in_ready_q  <= (state_d == ACC);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          if (count != '0) begin
            rem_d   = count;
            state_d = ACC;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACC: begin
        // in_ready_q is high throughout ACC, so in_valid alone marks a beat
        if (in_valid && in_ready_q) begin
          acc_d = add_c;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sum       = acc_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: table-driven runs with a
// scoreboard queue of expected sums, plus hand-written reset sequences.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  count;
  logic [7:0]  R;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] sum;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [11:0] sb_q[$];

  typedef struct packed {
    logic [3:0]       cnt;
    logic [14:0][7:0] prod;
    logic [3:0]       gap;
    logic [3:0]       bp;
    logic [11:0]      exp;
  } vec_t;

  vec_t vecs[7];

  product_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .count     (count),
    .R         (R),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One run: start, beats with optional stalls, then DONE with optional
  // backpressure during which start and stray products must be ignored.
  task automatic run_vec(input vec_t v);
    logic [11:0] exp_sum;
    start = 1'b1;
    count = v.cnt;
    sb_q.push_back(v.exp);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int i = 0; i < int'(v.cnt); i++) begin
      for (int g = 0; g < int'(v.gap); g++) begin
        in_valid = 1'b0;
        R        = 8'hAA;
        check("stall_in_ready", in_ready, 1);
        @(negedge clk);
      end
      check("beat_in_ready", in_ready, 1);
      check("beat_out_valid", out_valid, 0);
      in_valid = 1'b1;
      R        = v.prod[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("out_valid_latency", out_valid, 1);
    check("done_in_ready", in_ready, 0);
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      exp_sum = 12'd0;
    end else begin
      exp_sum = sb_q.pop_front();
    end
    check("sum", sum, exp_sum);
    for (int b = 0; b < int'(v.bp); b++) begin
      start    = 1'b1;
      count    = 4'd3;
      in_valid = 1'b1;
      R        = 8'd77;
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_sum", sum, exp_sum);
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_out_valid", out_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_in_ready", in_ready, 0);
  endtask

  initial begin
    logic [11:0] acc;
    rst = 1'b1; start = 1'b0; count = '0; R = '0; in_valid = 1'b0; out_ready = 1'b0;

    vecs[0] = '0; vecs[0].cnt = 4'd3; vecs[0].exp = 12'd246;
    vecs[0].prod[0] = 8'd6; vecs[0].prod[1] = 8'd15; vecs[0].prod[2] = 8'd225;
    vecs[1] = '0; vecs[1].cnt = 4'd2; vecs[1].gap = 4'd3; vecs[1].exp = 12'd13;
    vecs[1].prod[0] = 8'd9; vecs[1].prod[1] = 8'd4;
    vecs[2] = '0; vecs[2].cnt = 4'd0; vecs[2].exp = 12'd0;
    vecs[3] = '0; vecs[3].cnt = 4'd15; vecs[3].exp = 12'd3375;
    for (int i = 0; i < 15; i++) vecs[3].prod[i] = 8'd225;
    vecs[4] = '0; vecs[4].cnt = 4'd4; vecs[4].gap = 4'd1; vecs[4].bp = 4'd5; vecs[4].exp = 12'd10;
    for (int i = 0; i < 4; i++) vecs[4].prod[i] = 8'(i + 1);
    vecs[5] = '0; vecs[5].cnt = 4'd1; vecs[5].bp = 4'd2; vecs[5].exp = 12'd255;
    vecs[5].prod[0] = 8'd255;
    vecs[6] = '0; vecs[6].cnt = 4'd5; vecs[6].gap = 4'd2;
    acc = '0;
    for (int i = 0; i < 5; i++) begin
      vecs[6].prod[i] = 8'($urandom_range(0, 255));
      acc = acc + 12'(vecs[6].prod[i]);
    end
    vecs[6].exp = acc;

    #1;
    check("reset_sum", sum, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    // Reset in the middle of a 15-beat run, away from any clock edge
    start = 1'b1; count = 4'd15;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; R = 8'd100;
      @(negedge clk);
    end
    check("midrun_sum", sum, 700);
    #2 rst = 1'b1;
    #1;
    check("async_rst_sum", sum, 0);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 0);
    check("async_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    // Without a fresh start, products are ignored
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; R = 8'd50;
      @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_in_ready", in_ready, 0);
      check("post_rst_sum", sum, 0);
    end
    in_valid = 1'b0;
    begin
      vec_t v;
      v = '0; v.cnt = 4'd1; v.exp = 12'd200; v.prod[0] = 8'd200;
      run_vec(v);
    end

    check("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
